// File: rtl/mem_rd_port_arbiter.sv
// Arbitrates the operand SRAM read port between the A and B address FIFOs and routes returns by tag.
// Build option: define ARB_FIXED_PRIO_A_EN for fixed A-over-B priority instead of round-robin.
module mem_rd_port_arbiter #(
  parameter int ADDR_WIDTH      = 16,
  parameter int BUS_WIDTH_BYTES = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DATA_FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable_i,
  input  logic [ADDR_WIDTH-1:0]        a_addr_i,
  input  logic                         a_valid_i,
  output logic                         a_pop_o,
  input  logic [ADDR_WIDTH-1:0]        b_addr_i,
  input  logic                         b_valid_i,
  output logic                         b_pop_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic                         mem_rd_o,
  input  logic [8*BUS_WIDTH_BYTES-1:0] mem_rdata_i,
  input  logic                         mem_rvalid_i,
  output logic [8*BUS_WIDTH_BYTES-1:0] a_data_o,
  output logic                         a_data_valid_o,
  output logic [8*BUS_WIDTH_BYTES-1:0] b_data_o,
  output logic                         b_data_valid_o,
  input  logic                         a_data_pop_i,
  input  logic                         b_data_pop_i,
  output logic                         busy_o,
  output logic                         error_o
);

  localparam int DW = 8 * BUS_WIDTH_BYTES;
  localparam int CW = $clog2(DATA_FIFO_DEPTH) + 1;
  localparam int TW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [CW-1:0] CRED_MAX = CW'(DATA_FIFO_DEPTH);
  localparam logic [TW-1:0] TAG_MAX  = TW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cred_a_q, cred_a_d, cred_b_q, cred_b_d;
  logic [TW-1:0]         tag_cnt_q, tag_cnt_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic                  tag_mem_q [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_rd_q;
  logic [DW-1:0]         a_data_q, b_data_q;
  logic                  a_dv_q, b_dv_q;
  logic                  error_q;

  logic grant_ok, elig_a, elig_b, gnt_a, gnt_b;
  logic tag_push, tag_pop, rsp_tag;

  assign grant_ok = (state_q == RUN) && enable_i && (tag_cnt_q != TAG_MAX);
  assign elig_a   = grant_ok && a_valid_i && (cred_a_q != '0);
  assign elig_b   = grant_ok && b_valid_i && (cred_b_q != '0);

`ifdef ARB_FIXED_PRIO_A_EN
  assign gnt_a = elig_a;
  assign gnt_b = elig_b && !elig_a;
`else
  // Set after an A grant, so B is preferred next time both sides compete.
  logic rr_b_q;

  assign gnt_a = elig_a && (!elig_b || !rr_b_q);
  assign gnt_b = elig_b && (!elig_a || rr_b_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              rr_b_q <= 1'b0;
    else if (gnt_a || gnt_b) rr_b_q <= gnt_a;
  end
`endif

  assign a_pop_o  = gnt_a;
  assign b_pop_o  = gnt_b;
  assign tag_push = gnt_a || gnt_b;
  assign tag_pop  = mem_rvalid_i && (tag_cnt_q != '0);
  assign rsp_tag  = tag_mem_q[rd_ptr_q];

  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur,
                                                input logic gnt, input logic pop);
    logic [CW-1:0] res;
    res = cur;
    if (gnt && !pop)                          res = cur - CW'(1);
    else if (!gnt && pop && cur != CRED_MAX)  res = cur + CW'(1);
    return res;
  endfunction

  always_comb begin
    cred_a_d  = credit_next(cred_a_q, gnt_a, a_data_pop_i);
    cred_b_d  = credit_next(cred_b_q, gnt_b, b_data_pop_i);
    tag_cnt_d = tag_cnt_q;
    if (tag_push && !tag_pop)      tag_cnt_d = tag_cnt_q + TW'(1);
    else if (!tag_push && tag_pop) tag_cnt_d = tag_cnt_q - TW'(1);
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable_i) state_d = RUN;
      RUN:     if (!enable_i) state_d = DRAIN;
      DRAIN: begin
        if (enable_i)                                state_d = RUN;
        else if (tag_cnt_q == '0 && !mem_rvalid_i)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the tag array has no reset; entries are only read while the count says they are valid.
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem_q[wr_ptr_q] <= gnt_b;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cred_a_q   <= CRED_MAX;
      cred_b_q   <= CRED_MAX;
      tag_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      a_data_q   <= '0;
      b_data_q   <= '0;
      a_dv_q     <= 1'b0;
      b_dv_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cred_a_q  <= cred_a_d;
      cred_b_q  <= cred_b_d;
      tag_cnt_q <= tag_cnt_d;
      mem_rd_q  <= tag_push;
      if (tag_push) begin
        wr_ptr_q   <= wr_ptr_q + PW'(1);
        mem_addr_q <= gnt_a ? a_addr_i : b_addr_i;
      end
      if (tag_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      a_dv_q <= tag_pop && !rsp_tag;
      b_dv_q <= tag_pop && rsp_tag;
      if (tag_pop && !rsp_tag) a_data_q <= mem_rdata_i;
      if (tag_pop && rsp_tag)  b_data_q <= mem_rdata_i;
      // A return with nothing in flight is a protocol violation; latch it until reset.
      if (mem_rvalid_i && tag_cnt_q == '0) error_q <= 1'b1;
    end
  end

  assign mem_addr_o     = mem_addr_q;
  assign mem_rd_o       = mem_rd_q;
  assign a_data_o       = a_data_q;
  assign b_data_o       = b_data_q;
  assign a_data_valid_o = a_dv_q;
  assign b_data_valid_o = b_dv_q;
  assign error_o        = error_q;
  assign busy_o         = (state_q != IDLE) || (tag_cnt_q != '0);

endmodule

// File: tb/tb_mem_rd_port_arbiter.sv
// Randomized self-checking bench for mem_rd_port_arbiter against a queue-based cycle model.
module tb_mem_rd_port_arbiter;
  localparam int AW = 16;
  localparam int BB = 32;
  localparam int DW = 8 * BB;
  localparam int MO = 4;
  localparam int DD = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable_i;
  logic [AW-1:0] a_addr_i, b_addr_i, mem_addr_o;
  logic          a_valid_i, b_valid_i, a_pop_o, b_pop_o, mem_rd_o, mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i, a_data_o, b_data_o;
  logic          a_data_valid_o, b_data_valid_o, a_data_pop_i, b_data_pop_i, busy_o, error_o;

  always #5 clk = ~clk;

  mem_rd_port_arbiter #(.ADDR_WIDTH(AW), .BUS_WIDTH_BYTES(BB), .MAX_OUTSTANDING(MO),
                        .DATA_FIFO_DEPTH(DD)) dut (
    .clk(clk), .reset(reset), .enable_i(enable_i),
    .a_addr_i(a_addr_i), .a_valid_i(a_valid_i), .a_pop_o(a_pop_o),
    .b_addr_i(b_addr_i), .b_valid_i(b_valid_i), .b_pop_o(b_pop_o),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
    .a_data_o(a_data_o), .a_data_valid_o(a_data_valid_o),
    .b_data_o(b_data_o), .b_data_valid_o(b_data_valid_o),
    .a_data_pop_i(a_data_pop_i), .b_data_pop_i(b_data_pop_i),
    .busy_o(busy_o), .error_o(error_o)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: mode 0=idle, 1=run, 2=drain; tags held as a plain queue of sides.
  int            m_mode;
  bit            m_pref_b;
  int            m_cred_a, m_cred_b;
  bit            m_tags[$];
  bit            m_err;
  logic          e_rd, e_av, e_bv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_ad, e_bd;

  // Stimulus environment
  typedef struct {int due; logic [DW-1:0] data;} rsp_t;
  rsp_t          pend[$];
  logic [AW-1:0] qa[$], qb[$];
  logic [AW-1:0] issue_log[$];
  int cyc = 0, last_due = 0;
  int lat_lo = 1, lat_hi = 1, pop_pct = 0, spur_pct = 0, push_pct = 0;
  int occ_a = 0, occ_b = 0, issued = 0, outst = 0, max_outst = 0;
  bit en_k = 0, inject_rvalid = 0;

  function automatic int credit_upd(int c, bit g, bit p);
    if (g && p) return c;
    if (g) return c - 1;
    if (p && c < DD) return c + 1;
    return c;
  endfunction

  task automatic step();
    bit rv, pa, pb, can, ea, eb, ga, gb, side;
    int pre_cnt, due;
    logic [DW-1:0] rdata;
    // registered outputs from the previous cycle
    check("mem_rd", mem_rd_o, e_rd);
    check("mem_addr", mem_addr_o, e_addr);
    check("a_data_valid", a_data_valid_o, e_av);
    check("b_data_valid", b_data_valid_o, e_bv);
    if (e_av) check("a_data", a_data_o, e_ad);
    if (e_bv) check("b_data", b_data_o, e_bd);
    check("error", error_o, m_err);
    if (mem_rd_o) begin
      issued++;
      issue_log.push_back(mem_addr_o);
      outst++;
      if (outst > max_outst) max_outst = outst;
    end
    if (e_av) occ_a++;
    if (e_bv) occ_b++;
    // drive this cycle
    if ($urandom_range(99) < push_pct && qa.size() < 12) qa.push_back(AW'($urandom));
    if ($urandom_range(99) < push_pct && qb.size() < 12) qb.push_back(AW'($urandom));
    a_valid_i = qa.size() > 0;
    a_addr_i  = a_valid_i ? qa[0] : AW'($urandom);
    b_valid_i = qb.size() > 0;
    b_addr_i  = b_valid_i ? qb[0] : AW'($urandom);
    enable_i  = en_k;
    rdata = {8{$urandom}};
    rv = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rv = 1'b1;
      rdata = pend[0].data;
      void'(pend.pop_front());
    end else if (inject_rvalid) begin
      rv = 1'b1;
      inject_rvalid = 1'b0;
    end
    if (rv && outst > 0) outst--;
    mem_rvalid_i = rv;
    mem_rdata_i  = rdata;
    pa = (occ_a > 0 && $urandom_range(99) < pop_pct) || ($urandom_range(99) < spur_pct);
    pb = (occ_b > 0 && $urandom_range(99) < pop_pct) || ($urandom_range(99) < spur_pct);
    if (pa && occ_a > 0) occ_a--;
    if (pb && occ_b > 0) occ_b--;
    a_data_pop_i = pa;
    b_data_pop_i = pb;
    #1;
    // combinational outputs
    can = (m_mode == 1) && en_k && (m_tags.size() < MO);
    ea = can && a_valid_i && (m_cred_a > 0);
    eb = can && b_valid_i && (m_cred_b > 0);
`ifdef ARB_FIXED_PRIO_A_EN
    ga = ea;
    gb = eb && !ea;
`else
    ga = ea && (!eb || !m_pref_b);
    gb = eb && (!ea || m_pref_b);
`endif
    check("a_pop", a_pop_o, ga);
    check("b_pop", b_pop_o, gb);
    check("busy", busy_o, (m_mode != 0) || (m_tags.size() != 0));
    // advance model
    pre_cnt = m_tags.size();
    e_av = 1'b0;
    e_bv = 1'b0;
    if (rv) begin
      if (pre_cnt > 0) begin
        side = m_tags.pop_front();
        if (side) begin e_bv = 1'b1; e_bd = rdata; end
        else      begin e_av = 1'b1; e_ad = rdata; end
      end else m_err = 1'b1;
    end
    e_rd = ga || gb;
    if (ga || gb) begin
      if (ga) begin e_addr = qa.pop_front(); m_tags.push_back(1'b0); end
      else    begin e_addr = qb.pop_front(); m_tags.push_back(1'b1); end
      m_pref_b = ga;
      due = cyc + 1 + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{due, {8{$urandom}}});
    end
    m_cred_a = credit_upd(m_cred_a, ga, pa);
    m_cred_b = credit_upd(m_cred_b, gb, pb);
    case (m_mode)
      0: if (en_k) m_mode = 1;
      1: if (!en_k) m_mode = 2;
      default: if (en_k) m_mode = 1; else if (pre_cnt == 0 && !rv) m_mode = 0;
    endcase
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_mode != 0 || m_tags.size() != 0 || pend.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_within_budget", n < budget, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable_i = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0; a_addr_i = '0; b_addr_i = '0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; a_data_pop_i = 1'b0; b_data_pop_i = 1'b0;
    m_mode = 0; m_pref_b = 1'b0; m_cred_a = DD; m_cred_b = DD; m_tags.delete(); m_err = 1'b0;
    e_rd = 1'b0; e_av = 1'b0; e_bv = 1'b0; e_addr = '0; e_ad = '0; e_bd = '0;
    qa.delete(); qb.delete(); occ_a = 0; occ_b = 0; outst = 0; en_k = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc += 2;
    check("rst_mem_rd", mem_rd_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, '0);
    check("rst_pops", {a_pop_o, b_pop_o}, 2'b00);
    check("rst_data_valid", {a_data_valid_o, b_data_valid_o}, 2'b00);
    check("rst_data", a_data_o | b_data_o, '0);
    check("rst_busy_error", {busy_o, error_o}, 2'b00);
    reset = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] exp_order[8];
    do_reset();

    // Interleaved A/B stream, fixed latency 3
    for (int i = 0; i < 4; i++) begin
      qa.push_back(AW'(32'h0000 + 32'h20 * i));
      qb.push_back(AW'(32'h1000 + 32'h20 * i));
    end
`ifdef ARB_FIXED_PRIO_A_EN
    exp_order = '{16'h0000, 16'h0020, 16'h0040, 16'h0060, 16'h1000, 16'h1020, 16'h1040, 16'h1060};
`else
    exp_order = '{16'h0000, 16'h1000, 16'h0020, 16'h1020, 16'h0040, 16'h1040, 16'h0060, 16'h1060};
`endif
    lat_lo = 3; lat_hi = 3; en_k = 1'b1;
    run(14);
    en_k = 1'b0;
    wait_idle(40);
    check("order_count", issue_log.size(), 8);
    for (int i = 0; i < 8 && i < issue_log.size(); i++) check("order_addr", issue_log[i], exp_order[i]);
    check("busy_after_last_return", busy_o, 1'b0);

    // Credit exhaustion on A alone
    pop_pct = 100; run(10); pop_pct = 0;
    for (int i = 0; i < 20; i++) qa.push_back(AW'(32'h4000 + 32'h20 * i));
    lat_lo = 2; lat_hi = 2; en_k = 1'b1; issued = 0;
    run(40);
    check("credit_limited_reads", issued, 8);
    pop_pct = 100; run(3); pop_pct = 0;
    run(20);
    check("credit_returned_reads", issued, 11);
    qa.delete(); en_k = 1'b0; pop_pct = 100;
    wait_idle(40);
    run(12);

    // Long latency, both sides backed up
    for (int i = 0; i < 8; i++) begin
      qa.push_back(AW'(32'h2000 + i));
      qb.push_back(AW'(32'h3000 + i));
    end
    lat_lo = 10; lat_hi = 10; en_k = 1'b1; max_outst = 0;
    run(60);
    check("max_outstanding", max_outst <= MO, 1'b1);
    en_k = 1'b0;
    wait_idle(60);
    run(10);

    // Drain with three reads in flight
    for (int i = 0; i < 3; i++) qa.push_back(AW'(32'h5000 + i));
    qa.push_back(16'h5555);
    lat_lo = 8; lat_hi = 8; en_k = 1'b1;
    run(4);
    en_k = 1'b0;
    check("drain_outstanding", m_tags.size(), 3);
    wait_idle(30);
    check("drain_left_addr", qa.size(), 1);
    check("drain_idle_busy", busy_o, 1'b0);
    qa.delete();

    // Unexpected return
    inject_rvalid = 1'b1;
    run(5);
    check("error_sticky", error_o, 1'b1);

    // Randomized traffic
    do_reset();
    spur_pct = 2;
    for (int blk = 0; blk < 50; blk++) begin
      en_k = ($urandom_range(9) < 8);
      lat_lo = $urandom_range(4, 1);
      lat_hi = lat_lo + $urandom_range(6);
      pop_pct = $urandom_range(100);
      push_pct = $urandom_range(90, 10);
      run(50);
    end
    spur_pct = 0; push_pct = 0; qa.delete(); qb.delete(); en_k = 1'b0; pop_pct = 100;
    wait_idle(200);

    // Reset with reads in flight: their late returns must flag an error
    for (int i = 0; i < 6; i++) qa.push_back(AW'($urandom));
    lat_lo = 6; lat_hi = 6; en_k = 1'b1;
    run(5);
    do_reset();
    run(30);
    check("error_after_reset_discard", error_o, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
